// File: rtl/calc_ctrl.sv
// calc_ctrl: keypad-driven calculator sequencer. Builds two signed decimal
// operands, issues one ALU operation over a start/finish handshake guarded by
// a watchdog, and holds the result (or an error) for the display path.
module calc_ctrl #(
    parameter int unsigned WIDTH       = 16,
    parameter int unsigned MAX_DIGITS  = 5,
    parameter int unsigned ALU_TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             key_valid,
    input  logic [3:0]       key_code,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_finish,
    input  logic             alu_ovf,
    output logic [WIDTH-1:0] alu_in1,
    output logic [WIDTH-1:0] alu_in2,
    output logic [1:0]       alu_op,
    output logic             alu_start,
    output logic [WIDTH-1:0] display_value,
    output logic             complete,
    output logic             error
);

    localparam int unsigned EW = WIDTH + 4;
    localparam int unsigned CW = $clog2(MAX_DIGITS + 1);
    localparam int unsigned TW = $clog2(ALU_TIMEOUT);

    localparam logic [EW-1:0] MAX_POS   = (EW'(1) << (WIDTH - 1)) - EW'(1);
    localparam logic [CW-1:0] CNT_FULL  = CW'(MAX_DIGITS);
    localparam logic [TW-1:0] TIMER_END = TW'(ALU_TIMEOUT - 1);

    localparam logic [3:0] K_ADD   = 4'd10;
    localparam logic [3:0] K_SUB   = 4'd11;
    localparam logic [3:0] K_MUL   = 4'd12;
    localparam logic [3:0] K_NEG   = 4'd13;
    localparam logic [3:0] K_EQUAL = 4'd14;
    localparam logic [3:0] K_CLEAR = 4'd15;

    typedef enum logic [2:0] {
        ENTER_A,
        ENTER_B,
        START,
        WAIT,
        RESULT,
        ERROR
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_mag, a_mag_nxt, b_mag, b_mag_nxt;
    logic             a_sign, a_sign_nxt, b_sign, b_sign_nxt;
    logic [CW-1:0]    a_cnt, a_cnt_nxt, b_cnt, b_cnt_nxt;
    logic [1:0]       op, op_nxt;
    logic [TW-1:0]    timer, timer_nxt;
    logic [WIDTH-1:0] r, r_nxt;
    logic [WIDTH-1:0] in1_nxt, in2_nxt, disp_nxt;
    logic [1:0]       alu_op_nxt;
    logic             start_nxt, complete_nxt, error_nxt;

    logic             is_digit, is_op;
    logic [1:0]       key_op;
    logic [EW-1:0]    a_ext, b_ext;
    logic [WIDTH-1:0] r_abs;

    // Two's complement value of a sign/magnitude operand, mod 2^WIDTH
    function automatic logic [WIDTH-1:0] to_val(input logic s, input logic [WIDTH-1:0] m);
        return s ? (~m + WIDTH'(1)) : m;
    endfunction

    // Candidate magnitude after appending one decimal digit
    function automatic logic [EW-1:0] append(input logic [WIDTH-1:0] m, input logic [3:0] d);
        return EW'(m) * EW'(10) + EW'(d);
    endfunction

    // Next-state, datapath and registered-output computation
    always_comb begin
        state_nxt  = state;
        a_mag_nxt  = a_mag;
        a_sign_nxt = a_sign;
        a_cnt_nxt  = a_cnt;
        b_mag_nxt  = b_mag;
        b_sign_nxt = b_sign;
        b_cnt_nxt  = b_cnt;
        op_nxt     = op;
        timer_nxt  = timer;
        r_nxt      = r;
        in1_nxt    = alu_in1;
        in2_nxt    = alu_in2;
        alu_op_nxt = alu_op;
        disp_nxt   = display_value;

        is_digit = (key_code <= 4'd9);
        is_op    = (key_code == K_ADD) || (key_code == K_SUB) || (key_code == K_MUL);
        key_op   = 2'(key_code - K_ADD);
        a_ext    = append(a_mag, key_code);
        b_ext    = append(b_mag, key_code);
        r_abs    = r[WIDTH-1] ? (~r + WIDTH'(1)) : r;

        case (state)
            ENTER_A: begin
                if (key_valid) begin
                    if (is_digit) begin
                        if ((a_cnt < CNT_FULL) && (a_ext <= MAX_POS)) begin
                            a_mag_nxt = WIDTH'(a_ext);
                            if (!((a_mag == '0) && (key_code == 4'd0)))
                                a_cnt_nxt = a_cnt + CW'(1);
                        end
                    end else if (key_code == K_NEG) begin
                        a_sign_nxt = ~a_sign;
                    end else if (is_op) begin
                        op_nxt    = key_op;
                        state_nxt = ENTER_B;
                    end
                end
            end
            ENTER_B: begin
                if (key_valid) begin
                    if (is_digit) begin
                        if ((b_cnt < CNT_FULL) && (b_ext <= MAX_POS)) begin
                            b_mag_nxt = WIDTH'(b_ext);
                            if (!((b_mag == '0) && (key_code == 4'd0)))
                                b_cnt_nxt = b_cnt + CW'(1);
                        end
                    end else if (key_code == K_NEG) begin
                        b_sign_nxt = ~b_sign;
                    end else if (is_op) begin
                        op_nxt = key_op;
                    end else if (key_code == K_EQUAL) begin
                        state_nxt = START;
                    end
                end
            end
            START: begin
                timer_nxt = '0;
                state_nxt = WAIT;
            end
            WAIT: begin
                timer_nxt = timer + TW'(1);
                if (alu_finish) begin
                    if (alu_ovf) begin
                        state_nxt = ERROR;
                    end else begin
                        r_nxt     = alu_out;
                        state_nxt = RESULT;
                    end
                end else if (timer == TIMER_END) begin
                    state_nxt = ERROR;
                end
            end
            RESULT: begin
                if (key_valid) begin
                    if (is_digit) begin
                        a_mag_nxt  = WIDTH'(key_code);
                        a_sign_nxt = 1'b0;
                        a_cnt_nxt  = (key_code != 4'd0) ? CW'(1) : CW'(0);
                        b_mag_nxt  = '0;
                        b_sign_nxt = 1'b0;
                        b_cnt_nxt  = '0;
                        state_nxt  = ENTER_A;
                    end else if (is_op) begin
                        a_mag_nxt  = r_abs;
                        a_sign_nxt = r[WIDTH-1];
                        a_cnt_nxt  = CNT_FULL;
                        b_mag_nxt  = '0;
                        b_sign_nxt = 1'b0;
                        b_cnt_nxt  = '0;
                        op_nxt     = key_op;
                        state_nxt  = ENTER_B;
                    end else if (key_code == K_EQUAL) begin
                        a_mag_nxt  = r_abs;
                        a_sign_nxt = r[WIDTH-1];
                        a_cnt_nxt  = CNT_FULL;
                        state_nxt  = START;
                    end
                end
            end
            ERROR: begin
                state_nxt = ERROR;
            end
            default: begin
                state_nxt = ENTER_A;
            end
        endcase

        // CLEAR overrides whatever the current state decided
        if (key_valid && (key_code == K_CLEAR)) begin
            state_nxt  = ENTER_A;
            a_mag_nxt  = '0;
            a_sign_nxt = 1'b0;
            a_cnt_nxt  = '0;
            b_mag_nxt  = '0;
            b_sign_nxt = 1'b0;
            b_cnt_nxt  = '0;
            op_nxt     = '0;
            timer_nxt  = '0;
            r_nxt      = '0;
        end

        start_nxt    = (state_nxt == START);
        complete_nxt = (state_nxt == RESULT);
        error_nxt    = (state_nxt == ERROR);

        if (state_nxt == START) begin
            in1_nxt    = to_val(a_sign_nxt, a_mag_nxt);
            in2_nxt    = to_val(b_sign_nxt, b_mag_nxt);
            alu_op_nxt = op_nxt;
        end

        case (state_nxt)
            ENTER_A: disp_nxt = to_val(a_sign_nxt, a_mag_nxt);
            ENTER_B: disp_nxt = to_val(b_sign_nxt, b_mag_nxt);
            RESULT:  disp_nxt = r_nxt;
            ERROR:   disp_nxt = '0;
            default: disp_nxt = display_value;
        endcase
    end

    // State, operand and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= ENTER_A;
            a_mag         <= '0;
            a_sign        <= 1'b0;
            a_cnt         <= '0;
            b_mag         <= '0;
            b_sign        <= 1'b0;
            b_cnt         <= '0;
            op            <= '0;
            timer         <= '0;
            r             <= '0;
            alu_in1       <= '0;
            alu_in2       <= '0;
            alu_op        <= '0;
            alu_start     <= 1'b0;
            display_value <= '0;
            complete      <= 1'b0;
            error         <= 1'b0;
        end else begin
            state         <= state_nxt;
            a_mag         <= a_mag_nxt;
            a_sign        <= a_sign_nxt;
            a_cnt         <= a_cnt_nxt;
            b_mag         <= b_mag_nxt;
            b_sign        <= b_sign_nxt;
            b_cnt         <= b_cnt_nxt;
            op            <= op_nxt;
            timer         <= timer_nxt;
            r             <= r_nxt;
            alu_in1       <= in1_nxt;
            alu_in2       <= in2_nxt;
            alu_op        <= alu_op_nxt;
            alu_start     <= start_nxt;
            display_value <= disp_nxt;
            complete      <= complete_nxt;
            error         <= error_nxt;
        end
    end

endmodule

// File: tb/tb_calc_ctrl.sv
// tb_calc_ctrl: directed scenarios for calc_ctrl with a hand-driven ALU.
module tb_calc_ctrl;

    localparam int unsigned WIDTH = 16;

    localparam logic [3:0] K_ADD   = 4'd10;
    localparam logic [3:0] K_SUB   = 4'd11;
    localparam logic [3:0] K_MUL   = 4'd12;
    localparam logic [3:0] K_NEG   = 4'd13;
    localparam logic [3:0] K_EQUAL = 4'd14;
    localparam logic [3:0] K_CLEAR = 4'd15;

    logic             clk = 1'b0;
    logic             reset;
    logic             key_valid;
    logic [3:0]       key_code;
    logic [WIDTH-1:0] alu_out;
    logic             alu_finish;
    logic             alu_ovf;
    logic [WIDTH-1:0] alu_in1;
    logic [WIDTH-1:0] alu_in2;
    logic [1:0]       alu_op;
    logic             alu_start;
    logic [WIDTH-1:0] display_value;
    logic             complete;
    logic             error;

    int vectors    = 0;
    int miscompares = 0;

    calc_ctrl #(.WIDTH(16), .MAX_DIGITS(5), .ALU_TIMEOUT(8)) dut (
        .clk(clk),
        .reset(reset),
        .key_valid(key_valid),
        .key_code(key_code),
        .alu_out(alu_out),
        .alu_finish(alu_finish),
        .alu_ovf(alu_ovf),
        .alu_in1(alu_in1),
        .alu_in2(alu_in2),
        .alu_op(alu_op),
        .alu_start(alu_start),
        .display_value(display_value),
        .complete(complete),
        .error(error)
    );

    always #5 clk = ~clk;

    // One key strobe, sampled on the posedge between two falling edges
    task automatic press(input logic [3:0] code);
        @(negedge clk);
        key_valid = 1'b1;
        key_code  = code;
        @(negedge clk);
        key_valid = 1'b0;
        key_code  = 4'd0;
    endtask

    // Bounded wait for alu_start, capture operands, then finish after 'delay' cycles
    task automatic alu_respond(input int delay, input logic [WIDTH-1:0] res, input logic ovf,
                               output logic [WIDTH-1:0] c1, output logic [WIDTH-1:0] c2,
                               output logic [1:0] cop, output int nstart, output bit seen);
        seen = 1'b0;
        nstart = 0;
        c1 = '0;
        c2 = '0;
        cop = '0;
        for (int i = 0; i < 10; i++) begin
            if (alu_start === 1'b1) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (seen) begin
            c1 = alu_in1;
            c2 = alu_in2;
            cop = alu_op;
            nstart = 1;
            for (int i = 0; i < delay; i++) begin
                @(negedge clk);
                if (alu_start === 1'b1) nstart++;
            end
            alu_out    = res;
            alu_ovf    = ovf;
            alu_finish = 1'b1;
            @(negedge clk);
            alu_finish = 1'b0;
            alu_ovf    = 1'b0;
            if (alu_start === 1'b1) nstart++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        key_valid = 1'b0;
        key_code = 4'd0;
        alu_out = '0;
        alu_finish = 1'b0;
        alu_ovf = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        vectors++;
        if ({alu_in1, alu_in2, alu_op, alu_start} !== 35'd0) begin
            miscompares++;
            $display("FAIL reset_alu got in1=%0h in2=%0h op=%0h start=%0b expected all 0", alu_in1, alu_in2, alu_op, alu_start);
        end
        vectors++;
        if ({display_value, complete, error} !== 18'd0) begin
            miscompares++;
            $display("FAIL reset_disp got disp=%0h complete=%0b error=%0b expected all 0", display_value, complete, error);
        end
    endtask

    task automatic test_basic_add();
        logic [WIDTH-1:0] c1, c2;
        logic [1:0] cop;
        int ns;
        bit seen;
        press(4'd1); press(4'd2); press(4'd3);
        vectors++;
        if (display_value !== 16'd123) begin
            miscompares++;
            $display("FAIL add_disp_a got %0d expected 123", display_value);
        end
        press(K_ADD); press(4'd4); press(4'd5);
        vectors++;
        if (display_value !== 16'd45) begin
            miscompares++;
            $display("FAIL add_disp_b got %0d expected 45", display_value);
        end
        press(K_EQUAL);
        alu_respond(3, 16'd168, 1'b0, c1, c2, cop, ns, seen);
        vectors++;
        if (!seen) begin
            miscompares++;
            $display("FAIL add_start_seen got no alu_start expected one");
        end
        vectors++;
        if ({c1, c2, cop} !== {16'd123, 16'd45, 2'b00}) begin
            miscompares++;
            $display("FAIL add_operands got in1=%0d in2=%0d op=%0b expected 123 45 00", c1, c2, cop);
        end
        vectors++;
        if (ns !== 1) begin
            miscompares++;
            $display("FAIL add_start_count got %0d expected 1", ns);
        end
        vectors++;
        if ({display_value, complete, error} !== {16'd168, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL add_result got disp=%0d complete=%0b error=%0b expected 168 1 0", display_value, complete, error);
        end
    endtask

    task automatic test_chaining();
        logic [WIDTH-1:0] c1, c2;
        logic [1:0] cop;
        int ns;
        bit seen;
        press(K_MUL);
        vectors++;
        if ({display_value, complete} !== {16'd0, 1'b0}) begin
            miscompares++;
            $display("FAIL chain_enter_b got disp=%0d complete=%0b expected 0 0", display_value, complete);
        end
        press(4'd2); press(K_EQUAL);
        alu_respond(2, 16'd336, 1'b0, c1, c2, cop, ns, seen);
        vectors++;
        if (!seen || {c1, c2, cop} !== {16'd168, 16'd2, 2'b10}) begin
            miscompares++;
            $display("FAIL chain_operands got seen=%0b in1=%0d in2=%0d op=%0b expected 168 2 10", seen, c1, c2, cop);
        end
        vectors++;
        if ({display_value, complete} !== {16'd336, 1'b1}) begin
            miscompares++;
            $display("FAIL chain_result got disp=%0d complete=%0b expected 336 1", display_value, complete);
        end
        press(K_EQUAL);
        alu_respond(1, 16'd672, 1'b0, c1, c2, cop, ns, seen);
        vectors++;
        if (!seen || {c1, c2, cop} !== {16'd336, 16'd2, 2'b10}) begin
            miscompares++;
            $display("FAIL repeat_equals got seen=%0b in1=%0d in2=%0d op=%0b expected 336 2 10", seen, c1, c2, cop);
        end
        vectors++;
        if (display_value !== 16'd672) begin
            miscompares++;
            $display("FAIL repeat_result got %0d expected 672", display_value);
        end
        press(4'd7);
        vectors++;
        if ({display_value, complete} !== {16'd7, 1'b0}) begin
            miscompares++;
            $display("FAIL result_digit got disp=%0d complete=%0b expected 7 0", display_value, complete);
        end
    endtask

    task automatic test_digit_limits();
        press(K_CLEAR);
        press(4'd3); press(4'd2); press(4'd7); press(4'd6); press(4'd7); press(4'd8);
        vectors++;
        if (display_value !== 16'd32767) begin
            miscompares++;
            $display("FAIL limit_count got %0d expected 32767", display_value);
        end
        press(K_CLEAR);
        press(4'd3); press(4'd2); press(4'd7); press(4'd6); press(4'd8);
        vectors++;
        if (display_value !== 16'd3276) begin
            miscompares++;
            $display("FAIL limit_value got %0d expected 3276", display_value);
        end
        press(K_CLEAR);
        press(4'd0); press(4'd0); press(4'd1); press(4'd2);
        press(4'd3); press(4'd4); press(4'd5); press(4'd6);
        vectors++;
        if (display_value !== 16'd12345) begin
            miscompares++;
            $display("FAIL limit_zeros got %0d expected 12345", display_value);
        end
        vectors++;
        if (error !== 1'b0) begin
            miscompares++;
            $display("FAIL limit_no_error got %0b expected 0", error);
        end
    endtask

    task automatic test_signed_sub();
        logic [WIDTH-1:0] c1, c2;
        logic [1:0] cop;
        int ns;
        bit seen;
        press(K_CLEAR);
        press(K_NEG); press(4'd5);
        vectors++;
        if (display_value !== 16'hFFFB) begin
            miscompares++;
            $display("FAIL sub_neg_a got %0h expected fffb", display_value);
        end
        press(K_SUB); press(4'd7); press(K_EQUAL);
        alu_respond(2, 16'hFFF4, 1'b0, c1, c2, cop, ns, seen);
        vectors++;
        if (!seen || {c1, c2, cop} !== {16'hFFFB, 16'h0007, 2'b01}) begin
            miscompares++;
            $display("FAIL sub_operands got seen=%0b in1=%0h in2=%0h op=%0b expected fffb 0007 01", seen, c1, c2, cop);
        end
        vectors++;
        if ({display_value, complete} !== {16'hFFF4, 1'b1}) begin
            miscompares++;
            $display("FAIL sub_result got disp=%0h complete=%0b expected fff4 1", display_value, complete);
        end
        press(K_NEG);
        vectors++;
        if ({display_value, complete} !== {16'hFFF4, 1'b1}) begin
            miscompares++;
            $display("FAIL result_neg_ignored got disp=%0h complete=%0b expected fff4 1", display_value, complete);
        end
    endtask

    task automatic test_overflow();
        logic [WIDTH-1:0] c1, c2;
        logic [1:0] cop;
        int ns;
        bit seen;
        press(K_CLEAR);
        press(4'd2); press(K_MUL); press(4'd3); press(K_EQUAL);
        alu_respond(1, 16'd6, 1'b1, c1, c2, cop, ns, seen);
        vectors++;
        if (!seen || {error, complete, display_value} !== {1'b1, 1'b0, 16'd0}) begin
            miscompares++;
            $display("FAIL ovf_error got seen=%0b error=%0b complete=%0b disp=%0h expected 1 0 0", seen, error, complete, display_value);
        end
    endtask

    task automatic test_timeout();
        press(K_CLEAR);
        press(4'd1); press(K_ADD); press(4'd1); press(K_EQUAL);
        vectors++;
        if (alu_start !== 1'b1) begin
            miscompares++;
            $display("FAIL to_start got %0b expected 1", alu_start);
        end
        repeat (8) @(negedge clk);
        vectors++;
        if (error !== 1'b0) begin
            miscompares++;
            $display("FAIL to_early got error=%0b expected 0 after 7 wait cycles", error);
        end
        @(negedge clk);
        vectors++;
        if ({error, complete, display_value} !== {1'b1, 1'b0, 16'd0}) begin
            miscompares++;
            $display("FAIL to_error got error=%0b complete=%0b disp=%0h expected 1 0 0", error, complete, display_value);
        end
        alu_out = 16'd2;
        alu_finish = 1'b1;
        @(negedge clk);
        alu_finish = 1'b0;
        press(K_EQUAL); press(4'd5);
        vectors++;
        if ({error, complete, display_value} !== {1'b1, 1'b0, 16'd0}) begin
            miscompares++;
            $display("FAIL to_late_finish got error=%0b complete=%0b disp=%0h expected 1 0 0", error, complete, display_value);
        end
        press(K_CLEAR);
        vectors++;
        if ({error, complete, display_value} !== {1'b0, 1'b0, 16'd0}) begin
            miscompares++;
            $display("FAIL to_clear got error=%0b complete=%0b disp=%0h expected 0 0 0", error, complete, display_value);
        end
        press(4'd4);
        vectors++;
        if (display_value !== 16'd4) begin
            miscompares++;
            $display("FAIL to_enter_a got %0d expected 4", display_value);
        end
    endtask

    task automatic test_reset_midop();
        logic [WIDTH-1:0] c1, c2;
        logic [1:0] cop;
        int ns;
        bit seen;
        press(K_CLEAR);
        press(4'd7); press(K_ADD); press(4'd8); press(K_EQUAL);
        vectors++;
        if (alu_start !== 1'b1) begin
            miscompares++;
            $display("FAIL rst_start got %0b expected 1", alu_start);
        end
        #1 reset = 1'b1;
        #1;
        vectors++;
        if ({alu_in1, alu_in2, alu_op, alu_start, display_value, complete, error} !== 53'd0) begin
            miscompares++;
            $display("FAIL rst_async got in1=%0h in2=%0h op=%0h start=%0b disp=%0h complete=%0b error=%0b expected all 0",
                     alu_in1, alu_in2, alu_op, alu_start, display_value, complete, error);
        end
        @(negedge clk);
        reset = 1'b0;
        press(4'd9); press(K_ADD); press(4'd1); press(K_EQUAL);
        alu_respond(2, 16'd10, 1'b0, c1, c2, cop, ns, seen);
        vectors++;
        if (!seen || {c1, c2, cop} !== {16'd9, 16'd1, 2'b00}) begin
            miscompares++;
            $display("FAIL rst_after got seen=%0b in1=%0d in2=%0d op=%0b expected 9 1 00", seen, c1, c2, cop);
        end
        vectors++;
        if ({display_value, complete} !== {16'd10, 1'b1}) begin
            miscompares++;
            $display("FAIL rst_after_result got disp=%0d complete=%0b expected 10 1", display_value, complete);
        end
    endtask

    initial begin
        test_reset();
        test_basic_add();
        test_chaining();
        test_digit_limits();
        test_signed_sub();
        test_overflow();
        test_timeout();
        test_reset_midop();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/calc_ctrl.md
Name: calc_ctrl

Overview:
- Parametrised calculator sequencer; successor to the fixed 16-bit add-only controller.
- Accumulates signed decimal operands from a keypad and selects add, sub or mul.
- Drives an external ALU over a start/finish handshake with a watchdog timeout, and holds the result for display.
- Supports result chaining and repeat-equals; sits between the keypad decoder and the ALU/display path.

Parameters:
- WIDTH, 16: operand/result width, two's complement.
- MAX_DIGITS, 5: maximum significant decimal digits per operand.
- ALU_TIMEOUT, 64: WAIT cycles allowed before ERROR (>=2).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous active-high reset
- key_valid  in  1  one-cycle key strobe
- key_code  in  4  0-9 digit, 10 ADD, 11 SUB, 12 MUL, 13 NEG, 14 EQUAL, 15 CLEAR
- alu_out  in  WIDTH  ALU result
- alu_finish  in  1  ALU done strobe
- alu_ovf  in  1  ALU overflow, sampled with alu_finish
- alu_in1  out  WIDTH  operand A to ALU
- alu_in2  out  WIDTH  operand B to ALU
- alu_op  out  2  00 add, 01 sub, 10 mul
- alu_start  out  1  one-cycle start pulse
- display_value  out  WIDTH  signed value shown
- complete  out  1  result valid
- error  out  1  overflow/timeout flag

Behaviour:
- Reset: all outputs 0. State ENTER_A; magnitudes, signs, digit counts, op and timer cleared.
- Operand storage: sign bit plus WIDTH-bit magnitude. Value = sign ? -mag : mag, taken mod 2^WIDTH.
- Digit d is accepted only when count < MAX_DIGITS and mag*10+d <= 2^(WIDTH-1)-1. Compute in WIDTH+4 bits.
- Rejected digits are ignored silently, with no error.
- A zero digit with mag==0 does not increment count.
- display_value updates the cycle after the key.
- Keys are acted on only when key_valid=1; at most one key per cycle.
- CLEAR in any state: clear everything, go to ENTER_A, complete=0, error=0, alu_start=0.
- ENTER_A:
  - digit appends to A; NEG toggles A sign; EQUAL is ignored.
  - ADD/SUB/MUL latches op and goes to ENTER_B.
  - display_value = A.
- ENTER_B:
  - digit and NEG act on B; display_value = B.
  - An op key replaces the latched op.
  - EQUAL goes to START.
- START (1 cycle):
  - alu_start=1; alu_in1=A, alu_in2=B, alu_op=op.
  - These values are registered and held stable until the next START.
  - Next state WAIT, timer=0.
- WAIT:
  - alu_start=0; timer increments each cycle.
  - alu_finish=1 and alu_ovf=0: R=alu_out, display_value=R, complete=1, go to RESULT.
  - alu_finish=1 and alu_ovf=1: go to ERROR.
  - timer reaches ALU_TIMEOUT-1 without finish: go to ERROR.
  - finish wins if it arrives in the same cycle as timeout.
  - Non-CLEAR keys are ignored.
- RESULT: complete=1 and display_value=R held.
  - digit d: A=d (count 1 if d!=0), sign 0, B cleared, complete=0, go to ENTER_A.
  - op key: A=R (sign=R[MSB], mag=|R|, count=MAX_DIGITS), B cleared, latch op, complete=0, go to ENTER_B.
  - EQUAL: A=R, B unchanged, op unchanged, complete=0, go to START (repeat-equals).
  - NEG is ignored.
- ERROR: error=1, display_value=0, complete=0. Only CLEAR exits.
- alu_finish outside WAIT is ignored, including a late finish after ERROR or CLEAR.
- Reset mid-operation (any state, including WAIT with alu_start high) returns all outputs to 0 immediately.

Test Plan:
- Basic add: WIDTH=16; keys 1,2,3,ADD,4,5,EQUAL; ALU finishes 3 cycles after start with 168. Expect exactly one alu_start cycle with in1=123, in2=45, op=00; then display_value=168 and complete=1.
- Digit limits:
  - Keys 3,2,7,6,7,8: display 32767, the 8 is ignored.
  - After CLEAR, keys 3,2,7,6,8: display 3276.
  - After CLEAR, keys 0,0,1,2,3,4,5,6: display 12345.
- Signed sub: keys NEG,5,SUB,7,EQUAL. Expect in1=0xFFFB, in2=0x0007, op=01. On finish with 0xFFF4, display_value=0xFFF4 (-12).
- Chaining: from result 168, keys MUL,2,EQUAL give in1=168, in2=2, op=10. Finish with 336, then EQUAL gives in1=336, in2=2.
- Timeout: ALU_TIMEOUT=8, never assert finish. Expect error=1 after 8 WAIT cycles; a later finish is ignored; CLEAR gives error=0, state ENTER_A, display 0.
- Reset: assert reset during WAIT. All outputs are 0 asynchronously; after release, keys 9,ADD,1,EQUAL give in1=9, in2=1.
